// File: rtl/parking_slot_manager.sv
// N-slot parking controller: occupancy bitmap, lowest-free-slot allocation,
// timed entry door, and reject/illegal-exit pulses.
module parking_slot_manager #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 4,
  parameter int DOOR_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     occ_count,
  output logic [IDX_W-1:0]     best_slot,
  output logic                 best_valid,
  output logic                 full_light,
  output logic                 door_open,
  output logic                 entry_grant,
  output logic [IDX_W-1:0]     assigned_slot,
  output logic                 entry_reject,
  output logic                 exit_error
);

  localparam int HOLD_W = $clog2(DOOR_HOLD + 1);

  typedef enum logic {IDLE, OPEN} gate_st_e;

  gate_st_e              state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [NUM_SLOTS-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      aslot_q, aslot_d;
  logic                  grant_q, grant_d;
  logic                  reject_q, reject_d;
  logic                  xerr_q, xerr_d;
  logic                  exit_legal;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    best_slot  = '0;
    best_valid = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        best_slot  = IDX_W'(i);
        best_valid = 1'b1;
      end
    end
  end

  assign exit_legal = exit_req && (32'(exit_slot) < NUM_SLOTS) && occ_q[exit_slot];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    aslot_d  = aslot_q;
    grant_d  = 1'b0;
    reject_d = 1'b0;
    xerr_d   = exit_req && !exit_legal;

    case (state_q)
      IDLE: begin
        if (entry_req) begin
          if (best_valid) begin
            occ_d[best_slot] = 1'b1;
            aslot_d          = best_slot;
            grant_d          = 1'b1;
            hold_d           = HOLD_W'(DOOR_HOLD);
            state_d          = OPEN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      OPEN: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An allocated slot was free and an exited slot was occupied, so they never collide.
    if (exit_legal) occ_d[exit_slot] = 1'b0;

    case ({grant_d, exit_legal})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      aslot_q  <= '0;
      grant_q  <= 1'b0;
      reject_q <= 1'b0;
      xerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      aslot_q  <= aslot_d;
      grant_q  <= grant_d;
      reject_q <= reject_d;
      xerr_q   <= xerr_d;
    end
  end

  assign occupancy     = occ_q;
  assign occ_count     = cnt_q;
  assign full_light    = (cnt_q == CNT_W'(NUM_SLOTS));
  assign door_open     = (state_q == OPEN);
  assign entry_grant   = grant_q;
  assign assigned_slot = aslot_q;
  assign entry_reject  = reject_q;
  assign exit_error    = xerr_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench: an 8-slot and a 10-slot controller driven side by side,
// expected post-edge outputs queued at drive time and compared after the edge.
module tb_parking_slot_manager;

  localparam int HOLD = 4;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic       en8 = 0, ex8 = 0;
  logic [2:0] xs8 = 0;
  logic [7:0] occ8;
  logic [3:0] cnt8;
  logic [2:0] best8, as8;
  logic       bv8, full8, door8, gnt8, rej8, err8;

  logic       en10 = 0, ex10 = 0;
  logic [3:0] xs10 = 0;
  logic [9:0] occ10;
  logic [3:0] cnt10;
  logic [3:0] best10, as10;
  logic       bv10, full10, door10, gnt10, rej10, err10;

  parking_slot_manager #(.NUM_SLOTS(8), .IDX_W(3), .CNT_W(4), .DOOR_HOLD(HOLD)) u_dut8 (
    .clk(clk), .reset(reset), .entry_req(en8), .exit_req(ex8), .exit_slot(xs8),
    .occupancy(occ8), .occ_count(cnt8), .best_slot(best8), .best_valid(bv8),
    .full_light(full8), .door_open(door8), .entry_grant(gnt8), .assigned_slot(as8),
    .entry_reject(rej8), .exit_error(err8));

  parking_slot_manager #(.NUM_SLOTS(10), .IDX_W(4), .CNT_W(4), .DOOR_HOLD(HOLD)) u_dut10 (
    .clk(clk), .reset(reset), .entry_req(en10), .exit_req(ex10), .exit_slot(xs10),
    .occupancy(occ10), .occ_count(cnt10), .best_slot(best10), .best_valid(bv10),
    .full_light(full10), .door_open(door10), .entry_grant(gnt10), .assigned_slot(as10),
    .entry_reject(rej10), .exit_error(err10));

  typedef struct {
    int          d;
    logic [63:0] occ;
    int          cnt, best, bv, full, door, grant, as, rej, err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  logic [63:0] m_occ [2];
  int m_cnt [2], m_open [2], m_hold [2], m_as [2];
  int nslots [2] = '{8, 10};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int low_free(input logic [63:0] occ, input int n, output int valid);
    valid = 0;
    for (int i = 0; i < n; i++) if (!occ[i]) begin valid = 1; return i; end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_occ[d] = '0; m_cnt[d] = 0; m_open[d] = 0; m_hold[d] = 0; m_as[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic en, input logic ex, input int xs);
    exp_t e;
    int   n = nslots[d], bv, best, legal;
    logic [63:0] nocc = m_occ[d];
    best = low_free(m_occ[d], n, bv);
    e.d = d; e.grant = 0; e.rej = 0;
    legal = ex && (xs < n) && m_occ[d][xs];
    e.err = (ex && !legal) ? 1 : 0;
    if (m_open[d] == 0) begin
      if (en && bv == 1) begin
        e.grant = 1; nocc[best] = 1'b1; m_as[d] = best; m_cnt[d]++;
        m_open[d] = 1; m_hold[d] = HOLD;
      end else if (en) e.rej = 1;
    end else begin
      if (m_hold[d] == 1) m_open[d] = 0;
      m_hold[d]--;
    end
    if (legal) begin nocc[xs] = 1'b0; m_cnt[d]--; end
    m_occ[d] = nocc;
    e.occ = nocc; e.cnt = m_cnt[d]; e.as = m_as[d]; e.door = m_open[d];
    e.best = low_free(nocc, n, e.bv);
    e.full = (m_cnt[d] == n) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    string p = (e.d == 0) ? "d8" : "d10";
    if (e.d == 0) begin
      chk({p, ".occ"}, {56'd0, occ8}, e.occ);   chk({p, ".cnt"}, 64'(cnt8), 64'(e.cnt));
      chk({p, ".best"}, 64'(best8), 64'(e.best)); chk({p, ".bv"}, 64'(bv8), 64'(e.bv));
      chk({p, ".full"}, 64'(full8), 64'(e.full)); chk({p, ".door"}, 64'(door8), 64'(e.door));
      chk({p, ".grant"}, 64'(gnt8), 64'(e.grant)); chk({p, ".aslot"}, 64'(as8), 64'(e.as));
      chk({p, ".reject"}, 64'(rej8), 64'(e.rej)); chk({p, ".xerr"}, 64'(err8), 64'(e.err));
    end else begin
      chk({p, ".occ"}, {54'd0, occ10}, e.occ);  chk({p, ".cnt"}, 64'(cnt10), 64'(e.cnt));
      chk({p, ".best"}, 64'(best10), 64'(e.best)); chk({p, ".bv"}, 64'(bv10), 64'(e.bv));
      chk({p, ".full"}, 64'(full10), 64'(e.full)); chk({p, ".door"}, 64'(door10), 64'(e.door));
      chk({p, ".grant"}, 64'(gnt10), 64'(e.grant)); chk({p, ".aslot"}, 64'(as10), 64'(e.as));
      chk({p, ".reject"}, 64'(rej10), 64'(e.rej)); chk({p, ".xerr"}, 64'(err10), 64'(e.err));
    end
  endtask

  // One clock: queue expectations for the current inputs, then check after the edge.
  task automatic cyc();
    model_step(0, en8, ex8, int'(xs8));
    model_step(1, en10, ex10, int'(xs10));
    @(posedge clk); #1;
    while (q.size() > 0) compare(q.pop_front());
    en8 = 0; ex8 = 0; en10 = 0; ex10 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".occ8"}, {56'd0, occ8}, 64'd0);   chk({tag, ".cnt8"}, 64'(cnt8), 64'd0);
    chk({tag, ".best8"}, 64'(best8), 64'd0);     chk({tag, ".bv8"}, 64'(bv8), 64'd1);
    chk({tag, ".full8"}, 64'(full8), 64'd0);     chk({tag, ".door8"}, 64'(door8), 64'd0);
    chk({tag, ".gnt8"}, 64'(gnt8), 64'd0);       chk({tag, ".as8"}, 64'(as8), 64'd0);
    chk({tag, ".rej8"}, 64'(rej8), 64'd0);       chk({tag, ".err8"}, 64'(err8), 64'd0);
    chk({tag, ".occ10"}, {54'd0, occ10}, 64'd0); chk({tag, ".door10"}, 64'(door10), 64'd0);
    chk({tag, ".cnt10"}, 64'(cnt10), 64'd0);     chk({tag, ".as10"}, 64'(as10), 64'd0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_state("rst");
    reset = 0;
    @(posedge clk); #1;

    // first entry, then door timing and best_slot
    en8 = 1; cyc();
    chk("d8.first_occ", {56'd0, occ8}, 64'h01);
    chk("d8.first_best", 64'(best8), 64'd1);
    idle(4);
    chk("d8.door_closed", 64'(door8), 64'd0);

    // fill remaining 7 slots with 5-cycle spacing, then a 9th entry
    for (int i = 0; i < 7; i++) begin en8 = 1; cyc(); idle(4); end
    chk("d8.full_light", 64'(full8), 64'd1);
    chk("d8.full_cnt", 64'(cnt8), 64'd8);
    en8 = 1; cyc();
    chk("d8.reject9", 64'(rej8), 64'd1);
    idle(2);

    // exit slot 5 from full, then re-entry reuses it
    ex8 = 1; xs8 = 3'd5; cyc();
    chk("d8.occ_df", {56'd0, occ8}, 64'hDF);
    chk("d8.best5", 64'(best8), 64'd5);
    en8 = 1; cyc();
    chk("d8.assign5", 64'(as8), 64'd5);
    // requests during OPEN are ignored
    en8 = 1; cyc(); en8 = 1; cyc(); idle(3);

    // full lot, simultaneous entry and exit
    en8 = 1; ex8 = 1; xs8 = 3'd2; cyc();
    chk("d8.simul_rej", 64'(rej8), 64'd1);
    chk("d8.simul_cnt", 64'(cnt8), 64'd7);
    chk("d8.simul_occ", {56'd0, occ8}, 64'hFB);

    // 10-slot lot: empty-slot exit, out-of-range exit, fill, exit slot 9
    ex10 = 1; xs10 = 4'd3; cyc();
    chk("d10.empty_exit", 64'(err10), 64'd1);
    ex10 = 1; xs10 = 4'd12; cyc();
    for (int i = 0; i < 10; i++) begin en10 = 1; cyc(); idle(4); end
    ex10 = 1; xs10 = 4'd9; cyc();
    chk("d10.exit9_err", 64'(err10), 64'd0);
    chk("d10.exit9_occ", {54'd0, occ10}, 64'h1FF);

    // random traffic on both lots
    for (int i = 0; i < 300; i++) begin
      en8  = ($urandom_range(0, 2) == 0); ex8  = ($urandom_range(0, 3) == 0);
      xs8  = 3'($urandom_range(0, 7));
      en10 = ($urandom_range(0, 2) == 0); ex10 = ($urandom_range(0, 3) == 0);
      xs10 = 4'($urandom_range(0, 15));
      cyc();
    end
    idle(HOLD + 1);

    // clear, grant, then async reset mid-OPEN
    reset = 1; #2; reset = 0; model_reset();
    @(posedge clk); #1;
    en8 = 1; en10 = 1; cyc(); idle(1);
    chk("d8.open_pre_rst", 64'(door8), 64'd1);
    #3 reset = 1;
    #1 chk_reset_state("rst_open");
    model_reset();
    #1 reset = 0;
    @(posedge clk); #1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
